// File: rtl/sw_access_post_buffer.sv
`timescale 1ns/1ps
// sw_access_post_buffer
//   Posted-write buffer between the AHB-Lite widget's software-access port
//   and the generated register logic. Writes are pushed into a FIFO and
//   acknowledged right away. The FIFO drains one entry at a time to the
//   register logic. Reads wait until every posted write has drained, then
//   issue and return data plus error status.
//
// Optional feature: define SW_ACCESS_POST_BUFFER_TIMEOUT_EN to force an
//   error completion after TIMEOUT strobe cycles without reg_ack.
//
// Ports
//   bus_clk, bus_rst           clock, synchronous active-high reset
//   addr/w_vld/r_vld/byte_enable/sw_wr_bus   request from widget
//   sw_rd_bus/up_ack/up_err    completion to widget
//   reg_addr/reg_w_vld/reg_r_vld/reg_byte_enable/reg_wr_bus  strobe to regs
//   reg_rd_bus/reg_ack/reg_err response from regs
//   post_err                   pulse: a posted write finished with error
//   fifo_level                 posted-write FIFO occupancy (0..DEPTH)
module sw_access_post_buffer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst,
  input  logic [31:0]              addr,
  input  logic                     w_vld,
  input  logic                     r_vld,
  input  logic [3:0]               byte_enable,
  input  logic [31:0]              sw_wr_bus,
  output logic [31:0]              sw_rd_bus,
  output logic                     up_ack,
  output logic                     up_err,
  output logic [31:0]              reg_addr,
  output logic                     reg_w_vld,
  output logic                     reg_r_vld,
  output logic [3:0]               reg_byte_enable,
  output logic [31:0]              reg_wr_bus,
  input  logic [31:0]              reg_rd_bus,
  input  logic                     reg_ack,
  input  logic                     reg_err,
  output logic                     post_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT_DRAIN, RD_ISSUE, RD_RESP} state_t;

  state_t      state, state_nxt;
  wr_entry_t   mem [DEPTH];
  wr_entry_t   push_ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr, head_idx;
  logic [LW-1:0] lvl_rem;
  logic [31:0] rd_addr, issue_addr, rd_data_eff;
  logic        accept_ok, push, rd_accept, strobe, tmo, done, pop, rd_done;
  logic        err_eff, load_wr, drained, issue;

  assign accept_ok = (state == IDLE) && !up_ack;
  assign push      = accept_ok && w_vld && (fifo_level != LW'(DEPTH));
  // Simultaneous w_vld and r_vld: the write takes precedence.
  assign rd_accept = accept_ok && r_vld && !w_vld;
  assign push_ent  = '{addr: addr, be: byte_enable, data: sw_wr_bus};

  assign strobe  = reg_w_vld || reg_r_vld;
  assign done    = strobe && (reg_ack || tmo);
  assign pop     = reg_w_vld && done;
  assign rd_done = reg_r_vld && done;
  // tmo only fires without reg_ack, so a real ack keeps its own status.
  assign err_eff     = reg_err || tmo;
  assign rd_data_eff = tmo ? '0 : reg_rd_bus;

`ifdef SW_ACCESS_POST_BUFFER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? 16 : 8;
  logic [CW-1:0] tmo_cnt;

  assign tmo = strobe && !reg_ack && (tmo_cnt == CW'(TIMEOUT - 1));

  // Counts strobe cycles of the current access; a completion (which is
  // also when the next write is presented) restarts it.
  always_ff @(posedge bus_clk) begin
    if (bus_rst || !strobe || done) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // The presented entry stays in the FIFO until acked, so the level counts
  // it. After a pop the next head is either an older entry or, if the FIFO
  // would be empty, the write being pushed this cycle.
  assign lvl_rem  = fifo_level - LW'(pop);
  assign head_idx = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign head     = (lvl_rem != '0) ? mem[head_idx] : push_ent;
  assign load_wr  = (!reg_w_vld || pop) && ((lvl_rem != '0) || push);

  assign drained    = (fifo_level == '0) && !reg_w_vld;
  assign issue_addr = (state == IDLE) ? addr : rd_addr;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_accept) begin
          // Nothing to drain: skip the wait state so the strobe starts next cycle.
          if (drained) begin
            state_nxt = RD_ISSUE;
            issue     = 1'b1;
          end else begin
            state_nxt = RD_WAIT_DRAIN;
          end
        end
      end
      RD_WAIT_DRAIN: begin
        if (drained) begin
          state_nxt = RD_ISSUE;
          issue     = 1'b1;
        end
      end
      RD_ISSUE: if (rd_done) state_nxt = RD_RESP;
      RD_RESP:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      rd_addr         <= '0;
      up_ack          <= 1'b0;
      up_err          <= 1'b0;
      sw_rd_bus       <= '0;
      post_err        <= 1'b0;
      reg_addr        <= '0;
      reg_w_vld       <= 1'b0;
      reg_r_vld       <= 1'b0;
      reg_byte_enable <= '0;
      reg_wr_bus      <= '0;
    end else begin
      state      <= state_nxt;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (push)      wr_ptr  <= wr_ptr + 1'b1;
      if (pop)       rd_ptr  <= rd_ptr + 1'b1;
      if (rd_accept) rd_addr <= addr;

      up_ack    <= push || rd_done;
      up_err    <= rd_done && err_eff;
      sw_rd_bus <= rd_done ? rd_data_eff : '0;
      post_err  <= pop && err_eff;

      if (load_wr) begin
        reg_w_vld       <= 1'b1;
        reg_addr        <= head.addr;
        reg_byte_enable <= head.be;
        reg_wr_bus      <= head.data;
      end else if (pop) begin
        reg_w_vld <= 1'b0;
      end

      if (issue) begin
        reg_r_vld       <= 1'b1;
        reg_addr        <= issue_addr;
        reg_byte_enable <= '0;
        reg_wr_bus      <= '0;
      end else if (rd_done) begin
        reg_r_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_access_post_buffer.sv
`timescale 1ns/1ps
module tb_sw_access_post_buffer;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        bus_clk = 1'b0, bus_rst = 1'b1;
  logic [31:0] addr = '0, sw_wr_bus = '0, reg_rd_bus = '0;
  logic        w_vld = 1'b0, r_vld = 1'b0, reg_ack = 1'b0, reg_err = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] sw_rd_bus, reg_addr, reg_wr_bus;
  logic        up_ack, up_err, reg_w_vld, reg_r_vld, post_err;
  logic [3:0]  reg_byte_enable;
  logic [LW-1:0] fifo_level;

  sw_access_post_buffer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst), .addr(addr), .w_vld(w_vld), .r_vld(r_vld),
    .byte_enable(byte_enable), .sw_wr_bus(sw_wr_bus), .sw_rd_bus(sw_rd_bus),
    .up_ack(up_ack), .up_err(up_err), .reg_addr(reg_addr), .reg_w_vld(reg_w_vld),
    .reg_r_vld(reg_r_vld), .reg_byte_enable(reg_byte_enable), .reg_wr_bus(reg_wr_bus),
    .reg_rd_bus(reg_rd_bus), .reg_ack(reg_ack), .reg_err(reg_err),
    .post_err(post_err), .fifo_level(fifo_level));

  always #5 bus_clk = ~bus_clk;

  typedef struct { bit is_rd; logic [31:0] data; bit err; } exp_t;
  typedef struct { logic [31:0] a; logic [3:0] be; logic [31:0] d; } wr_t;

  exp_t sb_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  rsp_w;
  logic [31:0] arch_mem [16];   // architectural view: every write applied in issue order
  logic [31:0] reg_mem  [16];   // register logic contents as actually written
  int checks = 0, errors = 0, ack_prob = 0, post_exp = 0, post_seen = 0;
  bit pend = 0, pend_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  // Register map rule: the 0xF0 slot is unmapped and always errors.
  function automatic bit is_err_addr(logic [31:0] a);
    return a[7:4] == 4'hF;
  endfunction

  task automatic issue_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_t e; wr_t w;
    addr = a; byte_enable = be; sw_wr_bus = d; w_vld = 1'b1;
    e.is_rd = 0; e.data = '0; e.err = 0; sb_q.push_back(e);
    w.a = a; w.be = be; w.d = d; wr_q.push_back(w);
    if (!is_err_addr(a)) arch_mem[a[7:4]] = merge(arch_mem[a[7:4]], d, be);
  endtask

  task automatic issue_read(input logic [31:0] a);
    exp_t e;
    addr = a; r_vld = 1'b1;
    e.is_rd = 1; e.err = is_err_addr(a); e.data = e.err ? 32'h0 : arch_mem[a[7:4]];
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input int max, output bit got, output int cyc);
    got = 0; cyc = 0;
    while (!got && cyc < max) begin
      @(posedge bus_clk); #1; cyc++;
      if (up_ack) got = 1;
    end
    if (got) begin w_vld = 1'b0; r_vld = 1'b0; end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit got; int cyc;
    issue_write(a, be, d);
    wait_ack(300, got, cyc);
    chk("wr_acked", got, 1);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit got; int cyc;
    issue_read(a);
    wait_ack(300, got, cyc);
    chk("rd_acked", got, 1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((fifo_level != 0 || reg_w_vld || reg_r_vld) && n < max) begin
      @(posedge bus_clk); #1; n++;
    end
    chk("drained", {fifo_level != 0, reg_w_vld, reg_r_vld}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_up_ack"}, up_ack, 0);
    chk({tag, "_up_err"}, up_err, 0);
    chk({tag, "_rd_bus"}, sw_rd_bus, 0);
    chk({tag, "_reg_w_vld"}, reg_w_vld, 0);
    chk({tag, "_reg_r_vld"}, reg_r_vld, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_be"}, reg_byte_enable, 0);
    chk({tag, "_reg_wr_bus"}, reg_wr_bus, 0);
    chk({tag, "_post_err"}, post_err, 0);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic reset_and_resync(input string tag);
    bus_rst = 1'b1;
    @(posedge bus_clk); #1;
    chk_zero(tag);
    bus_rst = 1'b0; w_vld = 1'b0; r_vld = 1'b0;
    sb_q.delete(); wr_q.delete(); pend = 0;
    for (int i = 0; i < 16; i++) arch_mem[i] = reg_mem[i];   // queued writes are lost
    repeat (3) begin
      @(posedge bus_clk); #1;
      chk({tag, "_no_ack"}, up_ack, 0);
    end
  endtask

  // Scoreboard monitor: every completion pops the oldest expectation.
  always @(negedge bus_clk) begin
    if (!bus_rst && up_ack) begin
      if (sb_q.size() == 0) chk("unexpected_ack", up_ack, 0);
      else begin
        mon_e = sb_q.pop_front();
        chk("up_err", up_err, mon_e.err);
        chk("rd_data", sw_rd_bus, mon_e.is_rd ? mon_e.data : 32'h0);
      end
    end
  end

  // Register-logic responder: acks strobes at random, checks write order.
  always @(negedge bus_clk) begin
    if (pend) begin chk("post_err", post_err, pend_err); pend = 0; end
    if (post_err) post_seen++;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rd_bus = '0;
    if (!bus_rst && (reg_w_vld || reg_r_vld) && int'($urandom_range(99)) < ack_prob) begin
      reg_err = is_err_addr(reg_addr);
      if (reg_w_vld) begin
        if (wr_q.size() == 0) chk("wr_unexpected", reg_w_vld, 0);
        else begin
          rsp_w = wr_q.pop_front();
          chk("wr_addr", reg_addr, rsp_w.a);
          chk("wr_be", reg_byte_enable, rsp_w.be);
          chk("wr_data", reg_wr_bus, rsp_w.d);
        end
        if (!reg_err) reg_mem[reg_addr[7:4]] = merge(reg_mem[reg_addr[7:4]], reg_wr_bus, reg_byte_enable);
        else post_exp++;
        pend = 1; pend_err = reg_err;
      end else begin
        chk("rd_order", wr_q.size(), 0);
        reg_rd_bus = reg_err ? 32'h0 : reg_mem[reg_addr[7:4]];
      end
      reg_ack = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got; int cyc; logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin arch_mem[i] = '0; reg_mem[i] = '0; end
    repeat (3) @(posedge bus_clk); #1;
    chk_zero("rst");
    bus_rst = 1'b0;
    @(posedge bus_clk); #1;

`ifdef SW_ACCESS_POST_BUFFER_TIMEOUT_EN
    // Read never acked: forced error completion after TMO strobe cycles + 1.
    ack_prob = 0;
    issue_read(32'h20);
    sb_q[sb_q.size()-1].err = 1; sb_q[sb_q.size()-1].data = '0;
    wait_ack(40, got, cyc);
    chk("tmo_rd_got", got, 1);
    chk("tmo_rd_cyc", cyc, TMO + 1);
    @(posedge bus_clk); #1;
    // Write never acked: entry pops with a post_err pulse.
    issue_write(32'hF0, 4'hF, 32'hCAFE0001);
    wait_ack(10, got, cyc);
    chk("tmo_wr_ack_cyc", cyc, 1);
    repeat (TMO + 4) @(posedge bus_clk); #1;
    chk("tmo_wr_level", fifo_level, 0);
    post_exp++;
    wr_q.delete();
`else
    // Single write, ack one cycle after strobe.
    ack_prob = 100;
    issue_write(32'h0, 4'hF, 32'hDEADBEEF);
    @(posedge bus_clk); #1;
    chk("w1_up_ack", up_ack, 1);
    chk("w1_up_err", up_err, 0);
    chk("w1_reg_w_vld", reg_w_vld, 1);
    chk("w1_reg_wr_bus", reg_wr_bus, 32'hDEADBEEF);
    chk("w1_reg_be", reg_byte_enable, 4'hF);
    chk("w1_level", fifo_level, 1);
    w_vld = 1'b0;
    @(posedge bus_clk); #1;
    chk("w1_level_pop", fifo_level, 0);
    chk("w1_w_vld_drop", reg_w_vld, 0);

    // Fill: four acked, fifth stalls until the first pop.
    ack_prob = 0;
    for (int i = 0; i < 4; i++) begin
      issue_write(32'h10 * (i + 1), 4'hF, 32'h1000 + i);
      wait_ack(6, got, cyc);
      chk("fill_ack", got, 1);
    end
    chk("fill_level4", fifo_level, 4);
    issue_write(32'h50, 4'h3, 32'hA5A5_5A5A);
    wait_ack(6, got, cyc);
    chk("fill_stall", got, 0);
    chk("fill_stall_level", fifo_level, 4);
    ack_prob = 100;
    wait_ack(10, got, cyc);
    chk("fill_fifth_ack", got, 1);
    chk("fill_fifth_level", fifo_level, 3);
    wait_drain(50);

    // Two posted writes then a read: read waits behind both.
    ack_prob = 0;
    do_write(32'h10, 4'hF, 32'h12345678);
    do_write(32'h20, 4'h5, 32'h0BAD_F00D);
    issue_read(32'h10);
    repeat (4) begin
      @(posedge bus_clk); #1;
      chk("rd_waits", reg_r_vld, 0);
    end
    ack_prob = 100;
    wait_ack(20, got, cyc);
    chk("ord_rd_got", got, 1);
    @(posedge bus_clk); #1;

    // Read with empty FIFO: strobe next cycle, response cycle after ack.
    ack_prob = 0;
    issue_read(32'h10);
    @(posedge bus_clk); #1;
    chk("rd_strobe", reg_r_vld, 1);
    chk("rd_addr", reg_addr, 32'h10);
    ack_prob = 100;
    wait_ack(10, got, cyc);
    chk("rd_resp_cyc", cyc, 1);
    @(posedge bus_clk); #1;

    // Write to the erroring slot: up_err=0, post_err pulse later.
    do_write(32'hF0, 4'hF, 32'h0);
    wait_drain(20);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if (i % 20 == 0) ack_prob = $urandom_range(30, 100);
      idx = 4'($urandom_range(0, 15));
      if ($urandom_range(99) < 30) do_read({24'h0, idx, 4'h0});
      else do_write({24'h0, idx, 4'h0}, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge bus_clk);
      #1;
    end
    ack_prob = 100;
    wait_drain(200);
    repeat (2) @(posedge bus_clk); #1;

    // Reset with three writes queued and a read waiting behind them.
    ack_prob = 0;
    do_write(32'h30, 4'hF, 32'h33333333);
    do_write(32'h40, 4'hF, 32'h44444444);
    do_write(32'h50, 4'hF, 32'h55555555);
    issue_read(32'h30);
    repeat (2) begin
      @(posedge bus_clk); #1;
      chk("rst_rd_blocked", reg_r_vld, 0);
    end
    reset_and_resync("rst_q");

    // Reset with a read strobe outstanding.
    issue_read(32'h10);
    @(posedge bus_clk); #1;
    chk("rst_rd_issued", reg_r_vld, 1);
    reset_and_resync("rst_rd");

    // Traffic still works after reset.
    ack_prob = 100;
    do_write(32'h60, 4'hC, 32'h6666_0000);
    do_read(32'h60);
`endif

    ack_prob = 100;
    wait_drain(100);
    repeat (3) @(posedge bus_clk); #1;
    chk("sb_empty", sb_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("post_err_count", post_seen, post_exp);
    for (int i = 0; i < 16; i++) chk("mem_final", reg_mem[i], arch_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
